dm_bus_ctrl: RTL
================

// Module: dm_bus_ctrl
// PURPOSE
//   Data-memory access controller sitting directly downstream of the CPU's DM port.
//   It converts the CPU's single-cycle DM_enable/DM_write request into a req/ack
//   handshake toward a variable-latency data memory, and generates the CPU stall.
//   Writes are posted through a one-entry write buffer; reads stall the CPU until data returns.
//   A timeout counter aborts requests the memory never acknowledges.
// PARAMETERS
//   DATA_W    32   data width, CPU and memory side
//   ADDR_W    32   byte address width
//   TIMEOUT   64   max req-high cycles without mem_ack before abort (>=2)
// PORTS
//   clk         in   1       single clock, all logic on rising edge
//   rst         in   1       synchronous, active-low reset
//   DM_enable   in   1       CPU access request
//   DM_write    in   1       1=write, 0=read (valid with DM_enable)
//   DM_address  in   ADDR_W  CPU byte address
//   DM_in       in   DATA_W  CPU write data
//   DM_out      out  DATA_W  read data to CPU, valid when stall=0 after a read
//   stall       out  1       CPU must hold DM_* stable and freeze while 1
//   mem_req     out  1       request to memory, held until mem_ack or abort
//   mem_we      out  1       1=write request
//   mem_addr    out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//   mem_wdata   out  DATA_W  write data
//   mem_ack     in   1       one-cycle completion pulse; ignored unless mem_req=1
//   mem_rdata   in   DATA_W  read data, valid in the mem_ack cycle
//   bus_err     out  1       sticky timeout flag, cleared only by reset
// BEHAVIOUR
//   Reset (rst=0 at edge): state IDLE, wbuf empty, mem_req=0, DM_out=0, bus_err=0, cnt=0.
//   States: IDLE, WR_BUSY, RD_REQ, RD_DONE. mem_req=1 iff state in {WR_BUSY,RD_REQ}.
//   IDLE: DM_enable&DM_write -> capture addr/data into wbuf, ->WR_BUSY, stall=0 (posted).
//         DM_enable&!DM_write -> latch address, ->RD_REQ, stall=1 (combinational). No enable: stay.
//   WR_BUSY: drive wbuf on mem_*; mem_ack -> IDLE. New CPU access this state: stall=1,
//         except a read whose word address equals wbuf's: DM_out=wbuf data, stall=0, no mem access.
//         A write or non-matching read is held (stall=1) and accepted from IDLE after drain.
//   RD_REQ: stall=1; on mem_ack latch mem_rdata into DM_out register, ->RD_DONE.
//   RD_DONE: stall=0, DM_out held; CPU consumes; unconditionally ->IDLE (no re-issue).
//   Minimum read latency: 2 stall cycles (detect, RD_REQ with immediate ack); data in RD_DONE.
//   Timeout: cnt increments each cycle mem_req=1 && !mem_ack, clears on state change.
//     cnt==TIMEOUT-1 && !mem_ack -> abort: bus_err<=1; write ->IDLE (dropped);
//     read -> DM_out<=32'hDEAD_BEEF, ->RD_DONE.
//   mem_ack in the abort cycle wins over timeout. mem_ack while mem_req=0 is ignored.
//   DM_out keeps last value outside reads/forwards. Reset mid-transaction drops it; mem_req=0 next cycle.
//   Address bits [1:0] ignored (word access only); no byte enables.
// STRUCTURE
//   def.sv: dm_state_t enum (IDLE,WR_BUSY,RD_REQ,RD_DONE), DM_ABORT_DATA=32'hDEAD_BEEF.
//   Sub-module wait_timer: TIMEOUT counter with clear/enable inputs and expired output.
//   Top FSM, wbuf regs, forward compare and stall logic stay in dm_bus_ctrl.
// TESTING
//   Read 0x100, mem_ack in 1st req cycle, rdata=0x1234_5678 -> stall 2 cycles, DM_out=0x12345678 in RD_DONE.
//   Write 0x200=0xAAAA_5555, ack after 3 cycles -> stall=0 throughout; mem_req 3 cycles, mem_we=1, addr 0x200.
//   Write 0x300=0x11, then read 0x302 in WR_BUSY -> stall=0, DM_out=0x11, no read req issued.
//   Write 0x300, then read 0x400 before ack -> stall until drain, then normal read of 0x400.
//   Read with no ack, TIMEOUT=8 -> abort after 8 req cycles, DM_out=0xDEADBEEF, bus_err=1 sticky.
//   rst=0 during RD_REQ -> next cycle mem_req=0, stall=0, DM_out=0, bus_err=0.

Source files
------------

// File: rtl/dm_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
// Imported by the controller top and its wait timer.
package dm_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_BUSY,
    RD_REQ,
    RD_DONE
  } dm_state_t;

  localparam logic [31:0] DM_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dm_bus_ctrl_wait_timer.sv
// Request watchdog: counts stalled request cycles.
// Raises expired on the last permitted cycle.
module dm_bus_ctrl_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dm_bus_ctrl.sv
// CPU DM port to req/ack memory bridge with posted writes,
// write-buffer read forwarding and a request timeout.
module dm_bus_ctrl
  import dm_bus_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_enable,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  output logic [DATA_W-1:0] DM_out,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  dm_state_t state, state_n;

  logic [ADDR_W-3:0] wb_addr;
  logic [ADDR_W-3:0] rd_addr;
  logic [ADDR_W-3:0] sel_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] dout_q;
  logic [1:0]        lsb_unused;

  logic wb_load;
  logic rd_load;
  logic fwd;
  logic fwd_hit;
  logic abort;
  logic expired;
  logic tmr_clr;
  logic tmr_en;

  assign lsb_unused = DM_address[1:0];

  assign mem_req = (state == WR_BUSY) || (state == RD_REQ);
  assign mem_we  = (state == WR_BUSY);

  assign sel_addr  = mem_we ? wb_addr : rd_addr;
  assign mem_addr  = {sel_addr, 2'b00};
  assign mem_wdata = wb_data;

  assign fwd_hit = DM_enable && !DM_write &&
                   (DM_address[ADDR_W-1:2] == wb_addr);

  // A late ack still wins over the watchdog in the same cycle
  assign abort = mem_req && !mem_ack && expired;

  assign tmr_clr = (state_n != state);
  assign tmr_en  = mem_req && !mem_ack;

  dm_bus_ctrl_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    fwd     = 1'b0;
    wb_load = 1'b0;
    rd_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (DM_enable) begin
          if (DM_write) begin
            wb_load = 1'b1;
            state_n = WR_BUSY;
          end else begin
            rd_load = 1'b1;
            stall   = 1'b1;
            state_n = RD_REQ;
          end
        end
      end
      WR_BUSY: begin
        if (DM_enable) begin
          if (fwd_hit) fwd = 1'b1;
          else         stall = 1'b1;
        end
        if (mem_ack || abort) state_n = IDLE;
      end
      RD_REQ: begin
        stall = 1'b1;
        if (mem_ack || abort) state_n = RD_DONE;
      end
      RD_DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      wb_addr <= '0;
      wb_data <= '0;
      rd_addr <= '0;
      dout_q  <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      if (wb_load) begin
        wb_addr <= DM_address[ADDR_W-1:2];
        wb_data <= DM_in;
      end
      if (rd_load) rd_addr <= DM_address[ADDR_W-1:2];
      if (abort) bus_err <= 1'b1;
      if (fwd) begin
        dout_q <= wb_data;
      end else if (state == RD_REQ && mem_ack) begin
        dout_q <= mem_rdata;
      end else if (state == RD_REQ && abort) begin
        dout_q <= DATA_W'(DM_ABORT_DATA);
      end
    end
  end

  assign DM_out = fwd ? wb_data : dout_q;

endmodule
